// File: rtl/zxuno_regbus_master.sv
// Bridges CPU I/O cycles on two ports onto an 8-bit register bus: one port selects a
// register number, the other reads or writes the selected register.
module zxuno_regbus_master #(
  parameter logic [15:0] ADDR_PORT  = 16'hFC3B,
  parameter logic [15:0] DATA_PORT  = 16'hFD3B,
  parameter logic [7:0]  RESET_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regwr,
  output logic        zxuno_regrd,
  output logic [7:0]  reg_dout,
  input  logic [7:0]  reg_din,
  input  logic        reg_oe
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT_END} state_t;

  state_t     state, state_nxt;
  logic [7:0] rd_latch;
  logic       after_rst;
  logic       io_wr, io_rd, hit_addr, hit_data;
  logic       addr_load, dout_load, latch_load;

  // RD and WR both low is a bus fault, so neither decode fires.
  assign io_wr    = !iorq_n && !wr_n &&  rd_n;
  assign io_rd    = !iorq_n && !rd_n &&  wr_n;
  assign hit_addr = (a == ADDR_PORT);
  assign hit_data = (a == DATA_PORT);

  // NOTE: every output of a combinational block gets a default first, otherwise
  // any path that skips an assignment infers a latch.
  always_comb begin
    state_nxt  = state;
    addr_load  = 1'b0;
    dout_load  = 1'b0;
    latch_load = 1'b0;
    unique case (state)
      IDLE: begin
        // A strobe that was already low when reset released is not a new access.
        if (after_rst && !iorq_n) begin
          state_nxt = WAIT_END;
        end else if (io_wr && hit_addr) begin
          addr_load = 1'b1;
          state_nxt = WAIT_END;
        end else if (io_wr && hit_data) begin
          dout_load = 1'b1;
          state_nxt = WRITE;
        end else if (io_rd && hit_data) begin
          latch_load = 1'b1;
          state_nxt  = READ;
        end
      end
      WRITE:    state_nxt = WAIT_END;
      READ: begin
        latch_load = 1'b1;
        if (!io_rd) state_nxt = IDLE;
      end
      WAIT_END: if (iorq_n) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      after_rst   <= 1'b1;
      zxuno_addr  <= RESET_ADDR;
      reg_dout    <= 8'h00;
      rd_latch    <= 8'hFF;
      zxuno_regwr <= 1'b0;
      zxuno_regrd <= 1'b0;
    end else begin
      state       <= state_nxt;
      after_rst   <= 1'b0;
      zxuno_regwr <= (state_nxt == WRITE);
      zxuno_regrd <= (state_nxt == READ);
      if (addr_load)  zxuno_addr <= cpu_din;
      if (dout_load)  reg_dout   <= cpu_din;
      if (latch_load) rd_latch   <= reg_oe ? reg_din : 8'hFF;
    end
  end

  // Reading the address port is answered directly, without involving the FSM.
  always_comb begin
    cpu_oe   = 1'b0;
    cpu_dout = 8'hFF;
    if (io_rd && hit_addr) begin
      cpu_oe   = 1'b1;
      cpu_dout = zxuno_addr;
    end else if (state == READ) begin
      cpu_oe   = 1'b1;
      cpu_dout = rd_latch;
    end
  end

endmodule
